// File: rtl/sfx_sequencer_if.sv
// sfx_sequencer_if: signals between game logic, the sound-effect sequencer
// and the SN76477 parameter inputs.
//   trig/mute                   : requests and mute level into the sequencer
//   vco_freq .. mixer           : SN76477 parameter drives
//   busy/active_id/done         : sequencer status back to game logic
// Modports: slave = sequencer side, master = game-logic / bench side.
interface sfx_sequencer_if;
    logic [3:0] trig;
    logic       mute;
    logic [8:0] vco_freq;
    logic [7:0] noise_freq;
    logic [9:0] lfo_freq;
    logic       vco_select;
    logic       noise_select;
    logic [1:0] lfo_shift;
    logic [2:0] mixer;
    logic       busy;
    logic [1:0] active_id;
    logic       done;

    modport slave (
        input  trig, mute,
        output vco_freq, noise_freq, lfo_freq, vco_select, noise_select,
               lfo_shift, mixer, busy, active_id, done
    );

    modport master (
        output trig, mute,
        input  vco_freq, noise_freq, lfo_freq, vco_select, noise_select,
               lfo_shift, mixer, busy, active_id, done
    );
endinterface

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: arbitrates four sound-effect requests by fixed priority
// (higher index wins), loads the winner's preset onto the SN76477 parameter
// inputs, then sweeps the VCO or noise frequency once per tick for a fixed
// number of ticks.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : sfx_sequencer_if.slave (trig/mute in, SN76477 params + status out)
module sfx_sequencer #(
    parameter int TICK_DIV = 416667,
    parameter int CNT_W    = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    sfx_sequencer_if.slave       bus
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    // Which parameter the sweep acts on.
    localparam logic [1:0] TGT_NONE  = 2'd0;
    localparam logic [1:0] TGT_VCO   = 2'd1;
    localparam logic [1:0] TGT_NOISE = 2'd2;

    typedef struct packed {
        logic [8:0]        vco;
        logic [7:0]        noise;
        logic [9:0]        lfo;
        logic              vsel;
        logic              nsel;
        logic [1:0]        shift;
        logic [2:0]        mix;
        logic signed [5:0] delta;
        logic [1:0]        tgt;
        logic [6:0]        dur;
    } preset_t;

    function automatic preset_t preset(input logic [1:0] id);
        preset_t p;
        p = '0;
        case (id)
            2'd0: begin // blip
                p.vco = 9'd256; p.mix = 3'b001; p.delta = 6'sd8;
                p.tgt = TGT_VCO; p.dur = 7'd8;
            end
            2'd1: begin // laser
                p.vco = 9'd448; p.mix = 3'b001; p.delta = -6'sd16;
                p.tgt = TGT_VCO; p.dur = 7'd24;
            end
            2'd2: begin // explosion
                p.noise = 8'd224; p.nsel = 1'b1; p.mix = 3'b010;
                p.delta = -6'sd8; p.tgt = TGT_NOISE; p.dur = 7'd28;
            end
            default: begin // siren
                p.vco = 9'd128; p.lfo = 10'd384; p.vsel = 1'b1;
                p.shift = 2'b01; p.mix = 3'b001; p.delta = 6'sd0;
                p.tgt = TGT_NONE; p.dur = 7'd120;
            end
        endcase
        return p;
    endfunction

    // Saturating add: clamp to the parameter's range instead of wrapping.
    function automatic logic [8:0] sweep9(input logic [8:0] v, input logic signed [5:0] d);
        logic signed [10:0] s;
        s = $signed({2'b00, v}) + 11'(d);
        if (s < 0)           return 9'd0;
        else if (s > 11'sd511) return 9'h1ff;
        else                 return s[8:0];
    endfunction

    function automatic logic [7:0] sweep8(input logic [7:0] v, input logic signed [5:0] d);
        logic signed [9:0] s;
        s = $signed({2'b00, v}) + 10'(d);
        if (s < 0)           return 8'd0;
        else if (s > 10'sd255) return 8'hff;
        else                 return s[7:0];
    endfunction

    state_t            state;
    logic [3:0]        pending, pend_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [6:0]        dur;
    logic [8:0]        vco_q;
    logic [7:0]        noise_q;
    logic [9:0]        lfo_q;
    logic              vsel_q, nsel_q;
    logic [1:0]        shift_q;
    logic [2:0]        mix_q;
    logic signed [5:0] delta_q;
    logic [1:0]        tgt_q;
    logic [1:0]        active_q;
    logic              busy_q, done_q;
    logic [1:0]        sel;
    logic              hi_pend;
    preset_t           pre;

    always_comb begin
        sel = 2'd0;
        if      (pending[3]) sel = 2'd3;
        else if (pending[2]) sel = 2'd2;
        else if (pending[1]) sel = 2'd1;

        hi_pend = 1'b0;
        for (int i = 0; i < 4; i++)
            if (pending[i] && (i > int'(active_q))) hi_pend = 1'b1;

        // A new trig on the same cycle as its own clear keeps the bit set.
        pend_nxt = pending | bus.trig;
        if (state == LOAD)
            pend_nxt = (pending & ~(4'b0001 << sel)) | bus.trig;

        pre = preset(sel);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pending  <= '0;
            cnt      <= '0;
            dur      <= '0;
            vco_q    <= '0;
            noise_q  <= '0;
            lfo_q    <= '0;
            vsel_q   <= 1'b0;
            nsel_q   <= 1'b0;
            shift_q  <= '0;
            mix_q    <= '0;
            delta_q  <= '0;
            tgt_q    <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            pending <= pend_nxt;
            case (state)
                IDLE: begin
                    // Look at this cycle's trig too so LOAD follows a request
                    // by one cycle.
                    if ((pending | bus.trig) != 4'b0000) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    vco_q    <= pre.vco;
                    noise_q  <= pre.noise;
                    lfo_q    <= pre.lfo;
                    vsel_q   <= pre.vsel;
                    nsel_q   <= pre.nsel;
                    shift_q  <= pre.shift;
                    mix_q    <= pre.mix;
                    delta_q  <= pre.delta;
                    tgt_q    <= pre.tgt;
                    dur      <= pre.dur;
                    active_q <= sel;
                    cnt      <= '0;
                    state    <= PLAY;
                end
                PLAY: begin
                    if (dur == 7'd0) begin
                        // Last tick's value was shown for one cycle; now end.
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        vco_q    <= '0;
                        noise_q  <= '0;
                        lfo_q    <= '0;
                        vsel_q   <= 1'b0;
                        nsel_q   <= 1'b0;
                        shift_q  <= '0;
                        mix_q    <= '0;
                        active_q <= '0;
                    end else if (hi_pend) begin
                        state <= LOAD;
                    end else if (cnt == CNT_W'(TICK_DIV - 1)) begin
                        cnt <= '0;
                        dur <= dur - 7'd1;
                        if (tgt_q == TGT_VCO)   vco_q   <= sweep9(vco_q, delta_q);
                        if (tgt_q == TGT_NOISE) noise_q <= sweep8(noise_q, delta_q);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vco_freq     = vco_q;
    assign bus.noise_freq   = noise_q;
    assign bus.lfo_freq     = lfo_q;
    assign bus.vco_select   = vsel_q;
    assign bus.noise_select = nsel_q;
    assign bus.lfo_shift    = shift_q;
    assign bus.mixer        = bus.mute ? 3'b000 : mix_q;
    assign bus.busy         = busy_q;
    assign bus.active_id    = active_q;
    assign bus.done         = done_q;

endmodule
